// File: rtl/spi_reg_bridge.sv
// ---------------------------------------------------------------------------
// spi_reg_bridge
//   SPI slave (mode 0, MSB first) giving a host MCU access to the RTC register
//   file. 16-bit frames: bit15 RW (1=read), bits14:12 ignored, bits11:8 addr,
//   bits7:0 data. All SPI pins are oversampled in the clk domain.
//
// Ports
//   clk, rst_n     system clock (posedge), asynchronous active-low reset
//   spi_sclk       SPI clock from host (async, period >= 16 clk)
//   spi_cs_n       SPI chip select, active low (async)
//   spi_mosi       SPI data in (async)
//   spi_miso       SPI data out, 0 outside the data phase of a read
//   spi_miso_oe    pad output enable, 1 while synchronized cs_n is low
//   reg_addr       register file address, held between frames
//   reg_wdata      register file write data, held between frames
//   reg_write_en   1-clk write strobe
//   reg_read_en    1-clk read strobe
//   reg_rdata      register file read data (1-clk latency after read_en)
//   busy           1 from cs_n fall detection until return to IDLE
//   frame_err      1-clk pulse on aborted frame or out-of-range address
// ---------------------------------------------------------------------------
module spi_reg_bridge #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 8,
   parameter int NUM_REGS    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_sclk,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_write_en,
   output logic              reg_read_en,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              busy,
   output logic              frame_err
);

   typedef enum logic [2:0] {
      IDLE, CMD, RD_REQ, RD_WAIT, DATA, EXEC, DONE
   } state_e;

   state_e state_q, state_d;

   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic                   sclk_p_q, cs_p_q, cs_armed_q;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

   logic [3:0]        cnt_q;
   logic [DATA_W-1:0] rx_q, rx_next;
   logic [DATA_W-1:0] tx_q;
   logic              rw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              in_range;

   // ---------------------------------------------------------------- sync
   // Sync chains reset to 0 so that cs_n still low after a mid-frame reset is
   // not mistaken for a new falling edge; a fall is only seen after cs_n has
   // been observed high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         sclk_p_q    <= 1'b0;
         cs_p_q      <= 1'b0;
         cs_armed_q  <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         sclk_p_q    <= sclk_s;
         cs_p_q      <= cs_s;
         cs_armed_q  <= cs_armed_q | cs_s;
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_p_q;
   assign sclk_fall = ~sclk_s & sclk_p_q;
   assign cs_fall   = ~cs_s & cs_p_q;
   assign cs_rise   = cs_s & ~cs_p_q;

   assign rx_next  = {rx_q[DATA_W-2:0], mosi_s};
   assign in_range = 32'(addr_q) < NUM_REGS;

   // ---------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // --------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cs_fall) state_d = CMD;
         CMD: begin
            if (cs_rise)                          state_d = IDLE;
            else if (sclk_rise && cnt_q == 4'd7)  state_d = rx_next[7] ? RD_REQ : DATA;
         end
         RD_REQ:  state_d = cs_rise ? IDLE : RD_WAIT;
         RD_WAIT: state_d = cs_rise ? IDLE : DATA;
         DATA: begin
            if (cs_rise)                          state_d = IDLE;
            else if (sclk_rise && cnt_q == 4'd15) state_d = EXEC;
         end
         EXEC:    state_d = cs_rise ? IDLE : DONE;
         DONE:    if (cs_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------ outputs
   always_comb begin
      reg_write_en = (state_q == EXEC) && !rw_q && in_range;
      reg_read_en  = (state_q == RD_REQ) && in_range;
      busy         = (state_q != IDLE);
      spi_miso     = (state_q == DATA) && rw_q && tx_q[DATA_W-1];
      spi_miso_oe  = cs_armed_q && !cs_s;
      frame_err    = (cs_rise && (state_q == CMD || state_q == RD_REQ ||
                                  state_q == RD_WAIT || state_q == DATA))
                   || ((state_q == EXEC) && !rw_q && !in_range)
                   || ((state_q == RD_WAIT) && !in_range);
   end

   assign reg_addr  = addr_q;
   assign reg_wdata = wdata_q;

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         rx_q    <= '0;
         tx_q    <= '0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         if (state_q == IDLE) begin
            cnt_q <= '0;
         end else if (sclk_rise && (state_q == CMD || state_q == DATA)) begin
            cnt_q <= cnt_q + 4'd1;
            rx_q  <= rx_next;
         end

         if (state_q == CMD && sclk_rise && !cs_rise && cnt_q == 4'd7) begin
            rw_q   <= rx_next[7];
            addr_q <= rx_next[ADDR_W-1:0];
         end

         if (state_q == DATA && sclk_rise && !cs_rise && cnt_q == 4'd15 && !rw_q)
            wdata_q <= rx_next;

         // The fall right after the 8th rise (cnt 8) keeps bit 7 on miso so the
         // host can sample it on the 9th rise; later falls advance the shifter.
         if (state_q == RD_WAIT)
            tx_q <= in_range ? reg_rdata : '0;
         else if (state_q == DATA && sclk_fall && cnt_q != 4'd8)
            tx_q <= {tx_q[DATA_W-2:0], 1'b0};
      end
   end

endmodule

// File: tb/tb_spi_reg_bridge.sv
module tb_spi_reg_bridge;

   localparam int HALF = 100;  // SPI half period in ns (10 clk periods)

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       cs_n = 1'b1;
   logic       mosi = 1'b0;
   logic       miso, oe, we, re, busy, ferr;
   logic [3:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata = 8'h00;

   int checks = 0;
   int errors = 0;

   logic [7:0] rf_mem    [16];
   logic [7:0] model_mem [16];

   int         wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
   logic [3:0] wr_addr_l = '0, rd_addr_l = '0;
   logic [7:0] wr_data_l = '0;

   always #5 clk = ~clk;

   spi_reg_bridge #(
      .ADDR_W(4), .DATA_W(8), .NUM_REGS(8), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
      .spi_miso(miso), .spi_miso_oe(oe),
      .reg_addr(addr), .reg_wdata(wdata),
      .reg_write_en(we), .reg_read_en(re), .reg_rdata(rdata),
      .busy(busy), .frame_err(ferr)
   );

   // Register file stub: 1-clk read latency.
   always @(posedge clk) begin
      if (re) rdata <= rf_mem[addr];
      if (we) rf_mem[addr] <= wdata;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle compare process: strobe bookkeeping and idle-state rules.
   always @(negedge clk) begin
      if (rst_n) begin
         if (we)   begin wr_cnt++; wr_addr_l = addr; wr_data_l = wdata; end
         if (re)   begin rd_cnt++; rd_addr_l = addr; end
         if (ferr) err_cnt++;
         chk("strobe_excl", {31'd0, we & re}, 0);
         if (!busy) begin
            chk("idle_we", {31'd0, we}, 0);
            chk("idle_re", {31'd0, re}, 0);
            chk("idle_miso", {31'd0, miso}, 0);
         end
      end
   end

   // Drive nbits of a frame; returns the bits the host sampled on rises 9..16.
   task automatic drive_frame(input logic [15:0] w, input int nbits, input int gap_halves,
                              output logic [7:0] rx);
      rx = 8'h00;
      cs_n = 1'b0;
      #HALF;
      for (int i = 0; i < nbits; i++) begin
         mosi = w[15-i];
         #HALF;
         if (i == 4) begin
            chk("mid_busy", {31'd0, busy}, 1);
            chk("mid_oe", {31'd0, oe}, 1);
         end
         if (i >= 8) rx[15-i] = miso;
         sclk = 1'b1;
         #HALF;
         sclk = 1'b0;
      end
      #HALF;
      cs_n = 1'b1;
      mosi = 1'b0;
      #(gap_halves * HALF);
   endtask

   task automatic run_and_check(input logic [15:0] w, input int nbits, input int gap_halves,
                                output logic [7:0] rx);
      logic       rw, inr;
      logic [3:0] a;
      logic [7:0] d;
      int         exp_wr, exp_rd, exp_err, w0, r0, e0;
      rw  = w[15];
      a   = w[11:8];
      d   = w[7:0];
      inr = (a < 4'd8);
      exp_wr  = (nbits == 16 && !rw && inr) ? 1 : 0;
      exp_rd  = (nbits >= 8 && rw && inr) ? 1 : 0;
      exp_err = ((nbits < 16) ? 1 : 0)
              + ((nbits >= 8 && rw && !inr) ? 1 : 0)
              + ((nbits == 16 && !rw && !inr) ? 1 : 0);
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
      drive_frame(w, nbits, gap_halves, rx);
      chk("wr_pulses", wr_cnt - w0, exp_wr);
      chk("rd_pulses", rd_cnt - r0, exp_rd);
      chk("err_pulses", err_cnt - e0, exp_err);
      chk("busy_after", {31'd0, busy}, 0);
      if (exp_wr == 1) begin
         chk("wr_addr", {28'd0, wr_addr_l}, {28'd0, a});
         chk("wr_data", {24'd0, wr_data_l}, {24'd0, d});
         model_mem[a] = d;
      end
      if (exp_rd == 1) chk("rd_addr", {28'd0, rd_addr_l}, {28'd0, a});
      if (nbits == 16 && rw)
         chk("miso_byte", {24'd0, rx}, inr ? {24'd0, model_mem[a]} : 32'd0);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_miso"}, {31'd0, miso}, 0);
      chk({tag, "_oe"}, {31'd0, oe}, 0);
      chk({tag, "_addr"}, {28'd0, addr}, 0);
      chk({tag, "_wdata"}, {24'd0, wdata}, 0);
      chk({tag, "_we"}, {31'd0, we}, 0);
      chk({tag, "_re"}, {31'd0, re}, 0);
      chk({tag, "_busy"}, {31'd0, busy}, 0);
      chk({tag, "_ferr"}, {31'd0, ferr}, 0);
   endtask

   initial begin
      logic [7:0]  rx;
      logic [15:0] w;
      int          nb, w0, r0, e0;

      for (int i = 0; i < 16; i++) begin
         rf_mem[i]    = 8'($urandom);
         model_mem[i] = rf_mem[i];
      end

      #23;
      chk_outputs_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      #(4 * HALF);
      chk("idle_oe", {31'd0, oe}, 0);

      // Directed: write 0x035A, read it back.
      run_and_check(16'h035A, 16, 4, rx);
      chk("t1_addr", {28'd0, wr_addr_l}, 32'h3);
      chk("t1_data", {24'd0, wr_data_l}, 32'h5A);
      run_and_check(16'h8300, 16, 4, rx);
      chk("t2_rdata", {24'd0, rx}, 32'h5A);

      // Out-of-range write, then abort after 12 bits.
      run_and_check(16'h09AA, 16, 4, rx);
      run_and_check(16'h0466, 12, 4, rx);

      // Reset in the middle of a frame (after bit 10).
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
      w = 16'h0255;
      cs_n = 1'b0;
      #HALF;
      for (int i = 0; i < 10; i++) begin
         mosi = w[15-i]; #HALF; sclk = 1'b1; #HALF; sclk = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      chk_outputs_zero("midrst");
      #50;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 10; i < 16; i++) begin
         mosi = w[15-i]; #HALF; sclk = 1'b1; #HALF; sclk = 1'b0;
      end
      #HALF;
      cs_n = 1'b1;
      #(4 * HALF);
      chk("midrst_wr", wr_cnt - w0, 0);
      chk("midrst_rd", rd_cnt - r0, 0);
      chk("midrst_err", err_cnt - e0, 0);
      chk("midrst_busy", {31'd0, busy}, 0);
      run_and_check(16'h0711, 16, 4, rx);
      chk("t5_addr", {28'd0, wr_addr_l}, 32'h7);
      chk("t5_data", {24'd0, wr_data_l}, 32'h11);

      // Back-to-back write/read with a one-sclk-period cs_n gap.
      run_and_check(16'h0142, 16, 2, rx);
      run_and_check(16'h8100, 16, 4, rx);
      chk("t6_rdata", {24'd0, rx}, 32'h42);

      // Randomized frames.
      for (int k = 0; k < 40; k++) begin
         w = 16'($urandom);
         if ($urandom_range(0, 3) != 0) w[11:8] = 4'($urandom_range(0, 7));
         nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 16;
         run_and_check(w, nb, int'($urandom_range(2, 5)), rx);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
